// File: rtl/accel_pkg.sv
// Shared constants for the AI accelerator and its loaders: matrix limits,
// accelerator address prefixes, config-register values and the DMA state set.
// MATRIX_LOAD_AUTO_START_EN adds the CFG state used by the auto-start burst.
package accel_pkg;

    localparam int MEM_SIZE = 8;
    localparam int SEQ_BITS = 3;

    // Accelerator address space is split by addr[31:30].
    localparam logic [1:0] PFX_OP = 2'b00;
    localparam logic [1:0] PFX_A  = 2'b01;
    localparam logic [1:0] PFX_B  = 2'b10;
    localparam logic [1:0] PFX_C  = 2'b11;

    localparam logic [31:0] OP_MATMUL = 32'h0000_0001;
    localparam logic [31:0] GO_MAGIC  = 32'hFFFF_FFFF;

    // Index of the final register in the auto-start config burst.
    localparam logic [2:0] CFG_LAST = 3'd5;

`ifdef MATRIX_LOAD_AUTO_START_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_CFG  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3
    } state_t;
`endif

    // Element offset inside a matrix window: column in the low bits,
    // row starting just above the column field.
    function automatic logic [29:0] elem_offset(input logic [15:0] row,
                                                input logic [15:0] col,
                                                input int          seq_bits);
        return (30'(row) << (seq_bits + 1)) | 30'(col);
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One-shot Wishbone transaction engine. A request while idle launches a
// single strobe with registered address (and write data when we=1); the
// strobe holds until ack, then drops for at least one cycle. Read data is
// captured on ack. Acks seen while the strobe is low are ignored.
module wb_single_xfer (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stb_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic        done
);

    // Strobe/address/data registers: launch on request, retire on ack.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stb_o  <= 1'b0;
            addr_o <= '0;
            data_o <= '0;
        end else if (stb_o) begin
            if (ack_i) begin
                stb_o <= 1'b0;
                if (!we) begin
                    data_o <= data_i;
                end
            end
        end else if (req) begin
            stb_o  <= 1'b1;
            addr_o <= addr;
            if (we) begin
                data_o <= wdata;
            end
        end
    end

    assign done = stb_o & ack_i;

endmodule

// File: rtl/matrix_load_dma.sv
// Wishbone DMA that copies a rows x cols block of 32-bit words from system
// memory into the accelerator's matrix A or B window, one word at a time:
// read one word, write it, advance. Source rows are walked by accumulating
// the stride into row_base (no multiplier); addresses wrap modulo 2^32.
// Optional build macro MATRIX_LOAD_AUTO_START_EN: after a B load, write the
// six accelerator config registers (op, A dims, B dims, go) before done.
module matrix_load_dma
    import accel_pkg::*;
#(
    parameter int MEM_SIZE = accel_pkg::MEM_SIZE,
    parameter int SEQ_BITS = accel_pkg::SEQ_BITS
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [31:0] src_stride,
    input  logic [15:0] rows,
    input  logic [15:0] cols,
    input  logic        dest_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr_o,
    output logic        mem_stb_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic [31:0] acc_addr_o,
    output logic        acc_we_o,
    output logic        acc_stb_o,
    output logic [31:0] acc_data_o,
    input  logic        acc_ack_i
);

    state_t      state;
    logic [15:0] row, col, rows_q, cols_q;
    logic [31:0] row_base, stride_q;
    logic        dest_q;

    logic        mem_req, acc_req, mem_done, acc_done;
    logic [31:0] mem_addr_n, acc_addr_n, acc_wdata_n, mem_rdata;
    logic        bad_params, last_col, last_row;

`ifdef MATRIX_LOAD_AUTO_START_EN
    logic [15:0] a_rows, a_cols, b_rows, b_cols;
    logic [2:0]  cfg_idx;
`endif

    assign bad_params = (rows == 16'd0) || (cols == 16'd0) ||
                        (rows > 16'(MEM_SIZE)) || (cols > 16'(MEM_SIZE));
    assign last_col   = (col == cols_q - 16'd1);
    assign last_row   = (row == rows_q - 16'd1);

    // Every accelerator access is a write.
    assign acc_we_o = acc_stb_o;

    // Request/address/data selection for the two bus engines.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_req     = (state == ST_RD) && !mem_stb_o;
        mem_addr_n  = row_base + {14'd0, col, 2'b00};
        acc_req     = (state == ST_WR) && !acc_stb_o;
        acc_addr_n  = {(dest_q ? PFX_B : PFX_A), elem_offset(row, col, SEQ_BITS)};
        acc_wdata_n = mem_rdata;
`ifdef MATRIX_LOAD_AUTO_START_EN
        if (state == ST_CFG) begin
            acc_req    = !acc_stb_o;
            acc_addr_n = {PFX_OP, 26'd0, 1'b0, cfg_idx};
            case (cfg_idx)
                3'd0:    acc_wdata_n = OP_MATMUL;
                3'd1:    acc_wdata_n = {16'd0, a_cols};
                3'd2:    acc_wdata_n = {16'd0, a_rows};
                3'd3:    acc_wdata_n = {16'd0, b_cols};
                3'd4:    acc_wdata_n = {16'd0, b_rows};
                default: acc_wdata_n = GO_MAGIC;
            endcase
        end
`endif
    end

    // Transfer sequencing: parameter check, element walk, config burst, completion.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            row_base <= '0;
            stride_q <= '0;
            dest_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef MATRIX_LOAD_AUTO_START_EN
            a_rows   <= '0;
            a_cols   <= '0;
            b_rows   <= '0;
            b_cols   <= '0;
            cfg_idx  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (bad_params) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err      <= 1'b0;
                            rows_q   <= rows;
                            cols_q   <= cols;
                            stride_q <= src_stride;
                            dest_q   <= dest_sel;
                            row      <= '0;
                            col      <= '0;
                            row_base <= src_base;
                            busy     <= 1'b1;
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_done) begin
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (acc_done) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
`ifdef MATRIX_LOAD_AUTO_START_EN
                                if (dest_q) begin
                                    b_rows  <= rows_q;
                                    b_cols  <= cols_q;
                                    cfg_idx <= '0;
                                    state   <= ST_CFG;
                                end else begin
                                    a_rows <= rows_q;
                                    a_cols <= cols_q;
                                    state  <= ST_DONE;
                                end
`else
                                state <= ST_DONE;
`endif
                            end else begin
                                row      <= row + 16'd1;
                                row_base <= row_base + stride_q;
                                state    <= ST_RD;
                            end
                        end else begin
                            col   <= col + 16'd1;
                            state <= ST_RD;
                        end
                    end
                end
`ifdef MATRIX_LOAD_AUTO_START_EN
                ST_CFG: begin
                    if (acc_done) begin
                        if (cfg_idx == CFG_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            cfg_idx <= cfg_idx + 3'd1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_single_xfer u_mem_xfer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req      (mem_req),
        .we       (1'b0),
        .addr     (mem_addr_n),
        .wdata    (32'd0),
        .stb_o    (mem_stb_o),
        .addr_o   (mem_addr_o),
        .data_o   (mem_rdata),
        .data_i   (mem_data_i),
        .ack_i    (mem_ack_i),
        .done     (mem_done)
    );

    wb_single_xfer u_acc_xfer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req      (acc_req),
        .we       (1'b1),
        .addr     (acc_addr_n),
        .wdata    (acc_wdata_n),
        .stb_o    (acc_stb_o),
        .addr_o   (acc_addr_o),
        .data_o   (acc_data_o),
        .data_i   (32'd0),
        .ack_i    (acc_ack_i),
        .done     (acc_done)
    );

endmodule

// File: tb/tb_matrix_load_dma.sv
// Self-checking bench for matrix_load_dma. Memory and accelerator slaves with
// programmable wait states answer the DUT; a reference model derives the
// expected read addresses, accelerator writes and start-to-done latency.
`timescale 1ns/1ps
module tb_matrix_load_dma;
    import accel_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, start, dest_sel, mem_ack_i, acc_ack_i;
    logic [31:0] src_base, src_stride, mem_data_i;
    logic [15:0] rows, cols;
    logic        busy, done, err, mem_stb_o, acc_we_o, acc_stb_o;
    logic [31:0] mem_addr_o, acc_addr_o, acc_data_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       acc_log[$], exp_w[$];
    logic [31:0] mem_log[$], exp_r[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_delay = 0;
    int          acc_delay = 0;
    bit          spurious  = 1'b0;
    logic [31:0] seed;
    int          a_rows_m = 0, a_cols_m = 0, b_rows_m = 0, b_cols_m = 0;

    matrix_load_dma dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .src_base   (src_base),
        .src_stride (src_stride),
        .rows       (rows),
        .cols       (cols),
        .dest_sel   (dest_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr_o (mem_addr_o),
        .mem_stb_o  (mem_stb_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .acc_addr_o (acc_addr_o),
        .acc_we_o   (acc_we_o),
        .acc_stb_o  (acc_stb_o),
        .acc_data_o (acc_data_o),
        .acc_ack_i  (acc_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Memory contents: a scrambled function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ seed;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {26'd0, busy, done, err, mem_stb_o, acc_stb_o, acc_we_o}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_acc_addr"}, acc_addr_o, 32'd0);
        check({tag, "_acc_data"}, acc_data_o, 32'd0);
    endtask

    // Memory slave: acks after mem_delay wait states, checks strobe rules.
    initial begin : mem_slave
        int          wcnt;
        logic        prev_stb, prev_ack;
        logic [31:0] prev_addr;
        wcnt = 0; prev_stb = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (prev_ack) check("mem_stb_low_after_ack", 32'(mem_stb_o), 32'd0);
            else if (prev_stb === 1'b1 && mem_stb_o === 1'b1)
                check("mem_addr_stable", mem_addr_o, prev_addr);
            if (mem_stb_o === 1'b1) begin
                wcnt++;
                mem_ack_i = (wcnt > mem_delay);
            end else begin
                wcnt = 0;
                mem_ack_i = spurious && ($urandom_range(0, 1) == 1);
            end
            if (mem_ack_i && mem_stb_o === 1'b1) begin
                mem_data_i = mem_word(mem_addr_o);
                mem_log.push_back(mem_addr_o);
                wcnt = 0;
            end else begin
                mem_data_i = $urandom();
            end
            prev_stb  = mem_stb_o;
            prev_ack  = mem_ack_i && (mem_stb_o === 1'b1);
            prev_addr = mem_addr_o;
        end
    end

    // Accelerator slave: acks after acc_delay wait states, logs writes.
    initial begin : acc_slave
        int          wcnt;
        logic        prev_stb, prev_ack;
        logic [31:0] prev_addr, prev_data;
        wcnt = 0; prev_stb = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_data = '0;
        acc_ack_i = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (prev_ack) check("acc_stb_low_after_ack", 32'(acc_stb_o), 32'd0);
            else if (prev_stb === 1'b1 && acc_stb_o === 1'b1) begin
                check("acc_addr_stable", acc_addr_o, prev_addr);
                check("acc_data_stable", acc_data_o, prev_data);
            end
            if (acc_stb_o === 1'b1) begin
                wcnt++;
                acc_ack_i = (wcnt > acc_delay);
            end else begin
                wcnt = 0;
                acc_ack_i = spurious && ($urandom_range(0, 1) == 1);
            end
            if (acc_ack_i && acc_stb_o === 1'b1) begin
                check("acc_we", 32'(acc_we_o), 32'd1);
                acc_log.push_back({acc_addr_o, acc_data_o});
                wcnt = 0;
            end
            prev_stb  = acc_stb_o;
            prev_ack  = acc_ack_i && (acc_stb_o === 1'b1);
            prev_addr = acc_addr_o;
            prev_data = acc_data_o;
        end
    end

    // One complete load: build the expectation, pulse start, wait (bounded) for done, compare.
    task automatic run_load(input logic [31:0] base, input logic [31:0] stride,
                            input int r, input int c, input logic dest,
                            input int md, input int ad, input int inject_lat);
        bit          bad;
        int          exp_lat, lat, budget;
        logic [31:0] a;
        logic [31:0] cfg_words[6];
        bad = (r == 0) || (c == 0) || (r > MEM_SIZE) || (c > MEM_SIZE);
        exp_w.delete(); exp_r.delete(); mem_log.delete(); acc_log.delete();
        exp_lat = 2;
        if (!bad) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int cc = 0; cc < c; cc++) begin
                    a = base + 32'(rr) * stride + 32'(4 * cc);
                    exp_r.push_back(a);
                    exp_w.push_back({(dest ? PFX_B : PFX_A),
                                     30'(rr * (2 ** (SEQ_BITS + 1)) + cc), mem_word(a)});
                end
            end
            exp_lat = r * c * (4 + md + ad) + 2;
            if (!dest) begin a_rows_m = r; a_cols_m = c; end
            else       begin b_rows_m = r; b_cols_m = c; end
`ifdef MATRIX_LOAD_AUTO_START_EN
            if (dest) begin
                cfg_words = '{OP_MATMUL, 32'(a_cols_m), 32'(a_rows_m),
                              32'(b_cols_m), 32'(b_rows_m), GO_MAGIC};
                for (int i = 0; i < 6; i++) exp_w.push_back({32'(i), cfg_words[i]});
                exp_lat += 6 * (2 + ad);
            end
`endif
        end
        mem_delay = md;
        acc_delay = ad;
        @(negedge wb_clk_i);
        start = 1'b1; src_base = base; src_stride = stride;
        rows = 16'(r); cols = 16'(c); dest_sel = dest;
        budget = exp_lat + 100;
        lat = 0;
        do begin
            @(negedge wb_clk_i);
            lat++;
            start      = (lat == inject_lat);
            src_base   = $urandom();
            src_stride = $urandom();
            rows       = 16'($urandom_range(1, MEM_SIZE));
            cols       = 16'($urandom_range(1, MEM_SIZE));
            dest_sel   = 1'($urandom_range(0, 1));
            if (lat == 1) check("busy_after_start", 32'(busy), bad ? 32'd0 : 32'd1);
        end while (done !== 1'b1 && lat < budget);
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("start_to_done", 32'(lat), 32'(exp_lat));
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_flag", 32'(err), 32'(bad));
        check("n_reads", 32'(mem_log.size()), 32'(exp_r.size()));
        check("n_writes", 32'(acc_log.size()), 32'(exp_w.size()));
        foreach (exp_r[i]) if (i < mem_log.size()) check("rd_addr", mem_log[i], exp_r[i]);
        foreach (exp_w[i]) if (i < acc_log.size()) begin
            check("wr_addr", acc_log[i].addr, exp_w[i].addr);
            check("wr_data", acc_log[i].data, exp_w[i].data);
        end
        @(negedge wb_clk_i);
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_sticky", 32'(err), 32'(bad));
    endtask

    initial begin : main
        int n;
        seed = $urandom();
        wb_rst_i = 1'b1; start = 1'b0; dest_sel = 1'b0;
        src_base = '0; src_stride = '0; rows = '0; cols = '0;
        repeat (3) @(negedge wb_clk_i);
        check_reset_outputs("reset");
        wb_rst_i = 1'b0;

        // 2x3 into A, zero wait states: 26 cycles start to done.
        run_load(32'h0000_1000, 32'h0000_0020, 2, 3, 1'b0, 0, 0, 0);
        check("a_first_addr", acc_log[0].addr, 32'h4000_0000);
        check("a_last_addr", acc_log[5].addr, 32'h4000_0012);
        check("a_row1_src", mem_log[3], 32'h0000_1020);

        // Wait states with stray acks while strobes are low.
        spurious = 1'b1;
        run_load($urandom(), 32'h0000_0040, 3, 4, 1'b1, 5, 3, 0);
        for (int k = 0; k < 3; k++)
            run_load($urandom(), $urandom(), $urandom_range(1, MEM_SIZE),
                     $urandom_range(1, MEM_SIZE), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2), 0);
        spurious = 1'b0;

        // Parameter errors, then a valid load clears err.
        run_load(32'h0000_5000, 32'h0000_0020, 9, 2, 1'b0, 0, 0, 0);
        run_load(32'h0000_5000, 32'h0000_0020, 3, 0, 1'b1, 0, 0, 0);
        run_load(32'h0000_5000, 32'h0000_0020, 1, 1, 1'b0, 0, 0, 0);

        // Reset during the write of element 4 of an 8x8 B load.
        mem_delay = 0; acc_delay = 3;
        @(negedge wb_clk_i);
        start = 1'b1; src_base = 32'h0000_2000; src_stride = 32'h0000_0040;
        rows = 16'd8; cols = 16'd8; dest_sel = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        n = 0;
        while (!(acc_stb_o === 1'b1 && acc_addr_o === 32'h8000_0004) && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("rst_reached_elem4", acc_addr_o, 32'h8000_0004);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check_reset_outputs("midrst");
        wb_rst_i = 1'b0;
        a_rows_m = 0; a_cols_m = 0; b_rows_m = 0; b_cols_m = 0;
        run_load(32'h0000_6000, 32'h0000_0100, 2, 2, 1'b1, 0, 0, 0);
        check("restart_first_addr", acc_log[0].addr, 32'h8000_0000);

        // Source address wrap; a start pulse while busy must be ignored.
        run_load(32'hFFFF_FFFC, 32'h0000_0010, 1, 2, 1'b0, 0, 0, 3);
        check("wrap_rd1", mem_log[1], 32'h0000_0000);

`ifdef MATRIX_LOAD_AUTO_START_EN
        begin
            logic [31:0] cfg_exp[6];
            int          b0;
            cfg_exp = '{32'h1, 32'h3, 32'h2, 32'h2, 32'h3, 32'hFFFF_FFFF};
            run_load(32'h0000_7000, 32'h0000_0020, 2, 3, 1'b0, 0, 0, 0);
            run_load(32'h0000_8000, 32'h0000_0020, 3, 2, 1'b1, 0, 0, 0);
            b0 = acc_log.size() - 6;
            for (int i = 0; i < 6; i++) begin
                check("cfg_addr", acc_log[b0 + i].addr, 32'(i));
                check("cfg_data", acc_log[b0 + i].data, cfg_exp[i]);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
